// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/decode/execute sequencer for the 8-bit-address,
// 16-bit-data accumulator machine. The state register and the
// retired-instruction counter are the only storage. All datapath strobes
// are decoded combinationally from the state, the IR opcode and acc_zero.
module cpu_ctrl #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      ir,
    input  logic             acc_zero,
    output logic [2:0]       cs,
    output logic             addr_sel,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             ir_ld,
    output logic             ram_we,
    output logic             acc_ld,
    output logic [1:0]       alu_op,
    output logic             out_ld,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] inst_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH1 = 3'b001,
        S_FETCH2 = 3'b010,
        S_DECODE = 3'b011,
        S_EXEC1  = 3'b100,
        S_EXEC2  = 3'b101,
        S_HALT   = 3'b111
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_OUT   = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'hF);

    state_t            cs_q;
    state_t            cs_d;
    logic [CNT_W-1:0]  count_q;
    logic [OP_W-1:0]   op_s;
    logic              finish_s;
    logic              op_illegal_s;
    logic              unused_ir_s;

    assign op_s        = ir[15 -: OP_W];
    assign unused_ir_s = ^ir[15-OP_W:0];

    // Opcodes outside the defined set decode as NOP but raise illegal.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
            OP_JMP, OP_JZ, OP_OUT, OP_HALT: r = 1'b0;
            default:                        r = 1'b1;
        endcase
        return r;
    endfunction

    assign op_illegal_s = is_illegal(op_s);

    // Next-state selection and detection of the instruction's final cycle.
    always_comb begin
        cs_d     = S_IDLE;
        finish_s = 1'b0;
        case (cs_q)
            S_IDLE: begin
                if (run) begin
                    cs_d = S_FETCH1;
                end else begin
                    cs_d = S_IDLE;
                end
            end
            S_FETCH1: cs_d = S_FETCH2;
            S_FETCH2: cs_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: cs_d = S_EXEC1;
                    OP_HALT:                           cs_d = S_HALT;
                    default:                           finish_s = 1'b1;
                endcase
            end
            S_EXEC1: begin
                if (op_s == OP_STORE) begin
                    finish_s = 1'b1;
                end else begin
                    cs_d = S_EXEC2;
                end
            end
            S_EXEC2: finish_s = 1'b1;
            S_HALT:  cs_d = S_HALT;
            default: cs_d = S_IDLE;
        endcase
        // An instruction's last cycle samples run to decide whether to continue.
        if (finish_s) begin
            if (run) begin
                cs_d = S_FETCH1;
            end else begin
                cs_d = S_IDLE;
            end
        end else begin
            cs_d = cs_d;
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q    <= S_IDLE;
            count_q <= {CNT_W{1'b0}};
        end else begin
            cs_q <= cs_d;
            if (finish_s) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Strobe decode; every strobe is low unless the current state asks for it.
    always_comb begin
        addr_sel = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        ir_ld    = 1'b0;
        ram_we   = 1'b0;
        acc_ld   = 1'b0;
        alu_op   = 2'b00;
        out_ld   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (cs_q)
            S_FETCH1: addr_sel = 1'b0;
            S_FETCH2: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_DECODE: begin
                illegal = op_illegal_s;
                case (op_s)
                    OP_JMP:  pc_ld  = 1'b1;
                    OP_JZ:   pc_ld  = acc_zero;
                    OP_OUT:  out_ld = 1'b1;
                    default: pc_ld  = 1'b0;
                endcase
            end
            S_EXEC1: begin
                addr_sel = 1'b1;
                ram_we   = (op_s == OP_STORE);
            end
            S_EXEC2: begin
                addr_sel = 1'b1;
                acc_ld   = 1'b1;
                case (op_s)
                    OP_ADD:  alu_op = 2'b01;
                    OP_SUB:  alu_op = 2'b10;
                    default: alu_op = 2'b00;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign cs         = cs_q;
    assign inst_count = count_q;

endmodule
